pc_fetch_unit: RTL and testbench

Fetch-stage program counter and instruction-request controller for the pipelined core. It sits directly upstream of the hazard unit and IF/ID latch. It owns the PC, drives the instruction-memory read request, and accepts redirects (npc_change/npc) from the branch/jump resolution stage. It obeys the hazard unit's pc_WEN, parks a redirect that arrives while the PC is frozen, and stops fetching on halt.

---
 rtl/pc_fetch_unit.sv | 122 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC owner: drives instruction read requests and follows the hazard unit's pc_WEN.
// Redirects that arrive while the PC is frozen are parked, and fetching stops on halt.
//
// state           | meaning
// ----------------|--------------------------------------------------------------
// S_RUN           | normal fetch; PC advances or redirects on pc_WEN
// S_REDIRECT_WAIT | redirect parked in pend_target_q, applied on the next pc_WEN
// S_HALTED        | fetch stopped; only RST leaves
module pc_fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pc_WEN,
   input  logic             dpif_ihit,
   input  logic             npc_change,
   input  logic [31:0]      npc,
   input  logic             halt,
   output logic             imemREN,
   output logic [31:0]      imemaddr,
   output logic [31:0]      pc,
   output logic [31:0]      pcplus4,
   output logic             ifid_valid,
   output logic             redirect_pending,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [1:0] {
      S_RUN           = 2'd0,
      S_REDIRECT_WAIT = 2'd1,
      S_HALTED        = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        pend_target_q, pend_target_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        npc_aligned;
   logic [31:0]        pc_inc;
   logic               ren;
   logic               valid;

   assign npc_aligned = {npc[31:2], 2'b00};
   assign pc_inc      = pc_q + 32'd4;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_RUN;
         pc_q          <= PC_INIT;
         pend_target_q <= 32'h0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      ren           = 1'b0;
      valid         = 1'b0;
      case (state_q)
         S_RUN: begin
            ren   = 1'b1;
            valid = dpif_ihit & pc_WEN & ~npc_change & ~halt;
            if (npc_change) begin
               if (pc_WEN) begin
                  pc_d = npc_aligned;
               end else begin
                  pend_target_d = npc_aligned;
                  state_d       = S_REDIRECT_WAIT;
               end
            end else if (halt) begin
               state_d = S_HALTED;
            end else if (pc_WEN) begin
               pc_d = pc_inc;
            end
         end
         S_REDIRECT_WAIT: begin
            // Keep requesting the old PC so an in-flight access completes; later redirects are wrong-path.
            ren = 1'b1;
            if (pc_WEN) begin
               pc_d    = pend_target_q;
               state_d = S_RUN;
            end
         end
         S_HALTED: begin
            ren = 1'b0;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
      if (RST) begin
         ren   = 1'b0;
         valid = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (valid && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign imemREN          = ren;
   assign ifid_valid       = valid;
   assign imemaddr         = pc_q;
   assign pc               = pc_q;
   assign pcplus4          = pc_inc;
   assign redirect_pending = ~RST & (state_q == S_REDIRECT_WAIT);
   assign halted           = ~RST & (state_q == S_HALTED);
   assign fetch_count      = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, wrap/saturation sequence,
// and randomized traffic compared against a behavioural model of both instances.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        wen;
   logic        ihit;
   logic        chg;
   logic [31:0] npc_in;
   logic        hlt;

   logic        ren0, vld0, pnd0, hl0;
   logic [31:0] addr0, pc0, pc40;
   logic [31:0] cnt0;
   logic        ren1, vld1, pnd1, hl1;
   logic [31:0] addr1, pc1, pc41;
   logic [1:0]  cnt1;

   int checks = 0;
   int errors = 0;

   pc_fetch_unit dut (
      .CLK(clk), .RST(rst), .pc_WEN(wen), .dpif_ihit(ihit), .npc_change(chg),
      .npc(npc_in), .halt(hlt), .imemREN(ren0), .imemaddr(addr0), .pc(pc0),
      .pcplus4(pc40), .ifid_valid(vld0), .redirect_pending(pnd0), .halted(hl0),
      .fetch_count(cnt0)
   );

   pc_fetch_unit #(.PC_INIT(32'hFFFF_FFF8), .CNT_W(2)) dut_w (
      .CLK(clk), .RST(rst), .pc_WEN(wen), .dpif_ihit(ihit), .npc_change(chg),
      .npc(npc_in), .halt(hlt), .imemREN(ren1), .imemaddr(addr1), .pc(pc1),
      .pcplus4(pc41), .ifid_valid(vld1), .redirect_pending(pnd1), .halted(hl1),
      .fetch_count(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 = running, 1 = redirect parked, 2 = halted.
   typedef struct {
      int               mode;
      logic [31:0]      pc;
      logic [31:0]      pend;
      longint unsigned  cnt;
   } mdl_t;

   mdl_t m0, m1;

   function automatic bit m_valid(mdl_t m);
      return !rst && m.mode == 0 && wen && ihit && !chg && !hlt;
   endfunction

   function automatic mdl_t m_step(mdl_t m, longint unsigned cmax, logic [31:0] init);
      mdl_t n = m;
      if (rst) begin
         n.mode = 0; n.pc = init; n.pend = 32'h0; n.cnt = 0;
         return n;
      end
      if (m_valid(m) && n.cnt < cmax) n.cnt = n.cnt + 1;
      if (m.mode == 0) begin
         if (chg) begin
            if (wen) n.pc = npc_in & ~32'h3;
            else begin
               n.pend = npc_in & ~32'h3;
               n.mode = 1;
            end
         end else if (hlt) n.mode = 2;
         else if (wen) n.pc = m.pc + 32'd4;
      end else if (m.mode == 1) begin
         if (wen) begin
            n.pc = m.pend;
            n.mode = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m0 <= m_step(m0, 64'hFFFF_FFFF, 32'h0);
      m1 <= m_step(m1, 64'd3, 32'hFFFF_FFF8);
   end

   task automatic chk_model();
      chk("m0.ren",  ren0,  !rst && m0.mode != 2);
      chk("m0.addr", addr0, m0.pc);
      chk("m0.pc",   pc0,   m0.pc);
      chk("m0.pc4",  pc40,  32'(m0.pc + 32'd4));
      chk("m0.vld",  vld0,  m_valid(m0));
      chk("m0.pnd",  pnd0,  !rst && m0.mode == 1);
      chk("m0.hlt",  hl0,   !rst && m0.mode == 2);
      chk("m0.cnt",  cnt0,  m0.cnt);
      chk("m1.ren",  ren1,  !rst && m1.mode != 2);
      chk("m1.addr", addr1, m1.pc);
      chk("m1.pc4",  pc41,  32'(m1.pc + 32'd4));
      chk("m1.vld",  vld1,  m_valid(m1));
      chk("m1.pnd",  pnd1,  !rst && m1.mode == 1);
      chk("m1.hlt",  hl1,   !rst && m1.mode == 2);
      chk("m1.cnt",  cnt1,  m1.cnt);
   endtask

   typedef struct {
      logic        rst, wen, ihit, chg;
      logic [31:0] npc;
      logic        hlt;
      logic [31:0] addr;
      logic        ren, vld, pnd, hl;
      logic [31:0] cnt;
   } vec_t;

   function automatic vec_t v(logic r, logic w, logic ih, logic c, logic [31:0] n, logic h,
                              logic [31:0] a, logic re, logic va, logic p, logic hh, logic [31:0] ct);
      vec_t t;
      t.rst = r; t.wen = w; t.ihit = ih; t.chg = c; t.npc = n; t.hlt = h;
      t.addr = a; t.ren = re; t.vld = va; t.pnd = p; t.hl = hh; t.cnt = ct;
      return t;
   endfunction

   vec_t tv[22];
   logic [31:0] wrap_addr[5];

   initial begin
      rst = 1'b1; wen = 1'b0; ihit = 1'b0; chg = 1'b0; npc_in = 32'h0; hlt = 1'b0;

      //        rst w  ih c  npc       h  addr      ren vld pnd hl cnt
      tv[0]  = v(1, 0, 0, 0, 32'h0,   0, 32'h0,   0,  0,  0,  0, 0);
      tv[1]  = v(0, 1, 1, 0, 32'h0,   0, 32'h0,   1,  1,  0,  0, 0);
      tv[2]  = v(0, 1, 1, 0, 32'h0,   0, 32'h4,   1,  1,  0,  0, 1);
      tv[3]  = v(0, 1, 1, 0, 32'h0,   0, 32'h8,   1,  1,  0,  0, 2);
      tv[4]  = v(0, 1, 1, 0, 32'h0,   0, 32'hC,   1,  1,  0,  0, 3);
      tv[5]  = v(0, 1, 1, 1, 32'h103, 0, 32'h10,  1,  0,  0,  0, 4);
      tv[6]  = v(0, 0, 0, 0, 32'h0,   0, 32'h100, 1,  0,  0,  0, 4);
      tv[7]  = v(0, 0, 1, 1, 32'h200, 0, 32'h100, 1,  0,  0,  0, 4);
      tv[8]  = v(0, 0, 0, 0, 32'h0,   0, 32'h100, 1,  0,  1,  0, 4);
      tv[9]  = v(0, 0, 0, 1, 32'h300, 0, 32'h100, 1,  0,  1,  0, 4);
      tv[10] = v(0, 0, 0, 0, 32'h0,   1, 32'h100, 1,  0,  1,  0, 4);
      tv[11] = v(0, 1, 1, 1, 32'h300, 0, 32'h100, 1,  0,  1,  0, 4);
      tv[12] = v(0, 1, 1, 0, 32'h0,   0, 32'h200, 1,  1,  0,  0, 4);
      tv[13] = v(0, 1, 1, 0, 32'h0,   1, 32'h204, 1,  0,  0,  0, 5);
      tv[14] = v(0, 1, 1, 1, 32'h80,  0, 32'h204, 0,  0,  0,  1, 5);
      tv[15] = v(0, 1, 1, 0, 32'h0,   1, 32'h204, 0,  0,  0,  1, 5);
      tv[16] = v(1, 0, 0, 0, 32'h0,   0, 32'h204, 0,  0,  0,  0, 5);
      tv[17] = v(0, 1, 1, 1, 32'h83,  1, 32'h0,   1,  0,  0,  0, 0);
      tv[18] = v(0, 0, 0, 0, 32'h0,   0, 32'h80,  1,  0,  0,  0, 0);
      tv[19] = v(0, 0, 0, 1, 32'h500, 0, 32'h80,  1,  0,  0,  0, 0);
      tv[20] = v(1, 0, 0, 0, 32'h0,   0, 32'h80,  0,  0,  0,  0, 0);
      tv[21] = v(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  0,  0,  0, 0);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         rst = tv[i].rst; wen = tv[i].wen; ihit = tv[i].ihit;
         chg = tv[i].chg; npc_in = tv[i].npc; hlt = tv[i].hlt;
         #1;
         chk($sformatf("v%0d.addr", i), addr0, tv[i].addr);
         chk($sformatf("v%0d.pc4", i),  pc40,  32'(tv[i].addr + 32'd4));
         chk($sformatf("v%0d.ren", i),  ren0,  tv[i].ren);
         chk($sformatf("v%0d.vld", i),  vld0,  tv[i].vld);
         chk($sformatf("v%0d.pnd", i),  pnd0,  tv[i].pnd);
         chk($sformatf("v%0d.hlt", i),  hl0,   tv[i].hl);
         chk($sformatf("v%0d.cnt", i),  cnt0,  tv[i].cnt);
      end

      wrap_addr[0] = 32'hFFFF_FFF8; wrap_addr[1] = 32'hFFFF_FFFC;
      wrap_addr[2] = 32'h0;         wrap_addr[3] = 32'h4; wrap_addr[4] = 32'h8;
      @(negedge clk);
      rst = 1'b1; wen = 1'b0; ihit = 1'b0; chg = 1'b0; hlt = 1'b0;
      #1;
      chk("wrap.rst_ren", ren1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rst = 1'b0; wen = 1'b1; ihit = 1'b1;
         #1;
         chk($sformatf("wrap%0d.addr", i), addr1, wrap_addr[i]);
         chk($sformatf("wrap%0d.cnt", i),  cnt1,  (i < 3) ? i : 3);
         chk($sformatf("wrap%0d.vld", i),  vld1,  1'b1);
      end
      @(negedge clk);
      wen = 1'b0; ihit = 1'b0;
      #1;
      chk("wrap.sat_cnt", cnt1, 2'd3);

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst    = ($urandom_range(0, 39) == 0);
         wen    = ($urandom_range(0, 3) != 0);
         ihit   = $urandom_range(0, 1);
         chg    = ($urandom_range(0, 5) == 0);
         npc_in = $urandom;
         hlt    = ($urandom_range(0, 29) == 0);
         #1;
         chk_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
